input_conditioner: RTL and testbench

- Front-end conditioning stage for the Basys3 on-board inputs. Sits directly upstream of the basic I/O block, which presents switches and buttons to the CPU bus.
- Synchronises all 16 raw switch pins and 5 raw button pins to clk, then debounces each one.
- Drives clean, stable levels for each input.
- Keeps sticky per-button press flags that the CPU clears with write-1-to-clear.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_debounce_bit.sv | 54 +++++
 rtl/input_conditioner.sv | 67 ++++++
 tb/tb_input_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the Basys3 input front end.
// Button bit positions, default widths and the default debounce interval live
// here so that the downstream I/O block and this block agree on them.
package input_conditioner_pkg;

  // Button bit order on btn_raw / btn / btn_press
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int N_SW_DEFAULT  = 16;
  localparam int N_BTN_DEFAULT = 5;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: one input bit, two-flop synchroniser followed by a
// saturating-run debouncer.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous pin
//   level      : debounced level
//   rise, fall : single-cycle strobes, high on the edge that changes level
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic             stable;
  logic [CNT_W-1:0] count;
  logic             accept;

  // The change is accepted on the edge where the mismatch run reaches
  // DEBOUNCE_CYCLES; the strobes are asserted combinationally for that edge
  // so downstream registers update together with stable.
  assign accept = (s2 != stable) && (count == CNT_LAST);
  assign rise   = accept &  s2;
  assign fall   = accept & ~s2;
  assign level  = stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        count <= '0;
      end else if (accept) begin
        stable <= s2;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the Basys3 switches and
// buttons, and keeps sticky write-1-to-clear press flags per button.
//   clk, reset    : clock, synchronous active-high reset
//   sw_raw        : raw switch pins (async)
//   btn_raw       : raw button pins (async), order C,U,L,R,D
//   sw, btn       : debounced levels
//   btn_press     : sticky press flags, set on debounced rising edge
//   press_clr     : write-1-to-clear strobe for btn_press
//   btn_press_any : OR of btn_press
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  sw,
  output logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_press,
  input  logic [N_BTN-1:0] press_clr,
  output logic             btn_press_any
);

  logic [N_BTN-1:0] btn_rise;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .level(sw[i]),
      .rise (),
      .fall ()
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn[i]),
      .rise (btn_rise[i]),
      .fall ()
    );
  end

  // Set beats clear, so a press landing on the clear edge is not lost.
  always_ff @(posedge clk) begin
    if (reset) btn_press <= '0;
    else       btn_press <= btn_rise | (btn_press & ~press_clr);
  end

  assign btn_press_any = |btn_press;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

  localparam int N_SW  = 16;
  localparam int N_BTN = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] press_clr;
  logic             btn_press_any;

  int checks   = 0;
  int failures = 0;

  input_conditioner #(
    .N_SW           (N_SW),
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .btn_raw      (btn_raw),
    .sw           (sw),
    .btn          (btn),
    .btn_press    (btn_press),
    .press_clr    (press_clr),
    .btn_press_any(btn_press_any)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    sw_raw    = 16'hFFFF;
    btn_raw   = 5'h1F;
    press_clr = '0;

    // Reset held 3 edges with all inputs high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_sw", 32'(sw), 0);
      chk("rst_btn", 32'(btn), 0);
      chk("rst_press", 32'(btn_press), 0);
      chk("rst_any", 32'(btn_press_any), 0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rel_sw_early", 32'(sw), 0);
    end
    tick();
    chk("rel_sw_edge6", 32'(sw), 32'hFFFF);
    chk("rel_btn_edge6", 32'(btn), 32'h1F);

    // Return to a quiet baseline
    sw_raw  = '0;
    btn_raw = '0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk("base_sw", 32'(sw), 0);
    chk("base_press", 32'(btn_press), 0);

    // Clean press of btnC
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("press_btn_early", 32'(btn[0]), 0);
      chk("press_flag_early", 32'(btn_press[0]), 0);
    end
    tick();
    chk("press_btn", 32'(btn[0]), 1);
    chk("press_flag", 32'(btn_press[0]), 1);
    chk("press_any", 32'(btn_press_any), 1);
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("release_btn_early", 32'(btn[0]), 1);
    end
    tick();
    chk("release_btn", 32'(btn[0]), 0);
    chk("release_flag_kept", 32'(btn_press[0]), 1);
    press_clr[0] = 1'b1;
    tick();
    press_clr[0] = 1'b0;
    chk("clr_flag0", 32'(btn_press), 0);
    chk("clr_any", 32'(btn_press_any), 0);

    // Bounce on btnL: 1,0,1,0 then hold 1
    btn_raw[2] = 1'b1; tick(); chk("bounce_a", 32'(btn[2]), 0);
    btn_raw[2] = 1'b0; tick(); chk("bounce_b", 32'(btn[2]), 0);
    btn_raw[2] = 1'b1; tick(); chk("bounce_c", 32'(btn[2]), 0);
    btn_raw[2] = 1'b0; tick(); chk("bounce_d", 32'(btn[2]), 0);
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("bounce_hold_early", 32'(btn[2]), 0);
    end
    tick();
    chk("bounce_rise", 32'(btn[2]), 1);
    chk("bounce_flag", 32'(btn_press), 32'h04);
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("bounce_release", 32'(btn[2]), 0);
    press_clr = '1;
    tick();
    press_clr = '0;
    chk("bounce_clr", 32'(btn_press), 0);

    // Short glitch on sw[7]: 3 cycles high
    sw_raw[7] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_sw_hi", 32'(sw), 0);
    end
    sw_raw[7] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("glitch_sw_lo", 32'(sw), 0);
    end
    chk("glitch_count", 32'(dut.g_sw[7].u_db.count), 0);

    // Clear/set collision on btnU
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk("coll_btn_early", 32'(btn[1]), 0);
    press_clr[1] = 1'b1;
    tick();
    chk("coll_btn", 32'(btn[1]), 1);
    chk("coll_set_wins", 32'(btn_press[1]), 1);
    tick();
    press_clr[1] = 1'b0;
    chk("coll_clr_held", 32'(btn_press[1]), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("coll_stays_clr", 32'(btn_press[1]), 0);
      chk("coll_still_held", 32'(btn[1]), 1);
    end
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("coll_release", 32'(btn[1]), 0);
    chk("coll_release_flag", 32'(btn_press[1]), 0);

    // Reset in the middle of a btnD debounce
    btn_raw[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_pre", 32'(btn[4]), 0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in", 32'(btn[4]), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("midrst_early", 32'(btn[4]), 0);
    end
    tick();
    chk("midrst_rise", 32'(btn[4]), 1);
    chk("midrst_flag", 32'(btn_press), 32'h10);
    chk("midrst_any", 32'(btn_press_any), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
